// File: rtl/uart_pkg.sv
// uart_pkg: shared state/parity types and elaboration helpers for the UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Prefixed so the literals never collide with the receiver's PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int calc_div(input int clkHz, input int baud, input int os);
        int den;
        den = baud * os;
        if (den <= 0) return 0;
        return (clkHz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversampling tick, one clk-wide pulse every
// round(CLK_FREQ / (BAUD*OVERSAMPLE)) cycles; shared with the transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: clock too slow for requested BAUD*OVERSAMPLE");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= CW'(DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: parametrised RS-232 receiver with 3-sample majority voting, parity/framing/
// overrun reporting and valid/ready delivery. Break detection: define UART_RX_BREAK_DETECT_EN.
module uart_rx_gen2
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 25000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);
    localparam int PW = clog2(OVERSAMPLE);
    localparam int IW = clog2(DATA_BITS);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [PW-1:0] PH_LO    = PW'(M - 1);
    localparam logic [PW-1:0] PH_MID   = PW'(M);
    localparam logic [PW-1:0] PH_DEC   = PW'(M + 1);
    localparam logic [PW-1:0] PH_WRAP  = PW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic          ODD_FLIP = (PARITY == int'(PAR_ODD));
    localparam logic          HAS_PAR  = (PARITY != int'(PAR_NONE));

    if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_param
        $error("uart_rx_gen2: parameter out of range");
    end

    rx_state_e              state;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [PW-1:0]          phase;
    logic [IW-1:0]          bitIdx;
    logic [DATA_BITS-1:0]   shreg;
    logic [1:0]             samp;
    logic                   parErr;
    logic                   tick, lineS, maj, atDec, atWrap, isBreak;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) syncQ <= '1;
        else        syncQ <= {syncQ[SYNC_STAGES-2:0], rxd};
    end

    assign lineS  = syncQ[SYNC_STAGES-1];
    // Third sample is the live line on the decision tick itself.
    assign maj    = (samp[0] & samp[1]) | (samp[0] & lineS) | (samp[1] & lineS);
    assign atDec  = tick && (phase == PH_DEC);
    assign atWrap = tick && (phase == PH_WRAP);

`ifdef UART_RX_BREAK_DETECT_EN
    logic zeroSeen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                      zeroSeen <= 1'b0;
        else if (state == ST_IDLE)                                       zeroSeen <= 1'b1;
        else if (atDec && maj && (state inside {ST_DATA, ST_PARITY}))    zeroSeen <= 1'b0;
    end
    assign isBreak = zeroSeen && !maj;
`else
    assign isBreak = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            phase         <= '0;
            bitIdx        <= '0;
            shreg         <= '0;
            samp          <= '0;
            parErr        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            rx_break   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (tick && phase == PH_LO)  samp[0] <= lineS;
            if (tick && phase == PH_MID) samp[1] <= lineS;
            if (tick && state != ST_IDLE) phase <= (phase == PH_WRAP) ? '0 : phase + 1'b1;

            case (state)
                ST_IDLE: if (tick && !lineS) begin
                    state  <= ST_START;
                    phase  <= '0;
                    parErr <= 1'b0;
                end
                ST_START: begin
                    if (atDec && maj) begin
                        state <= ST_IDLE;
                    end else if (atWrap) begin
                        state  <= ST_DATA;
                        bitIdx <= '0;
                    end
                end
                ST_DATA: begin
                    if (atDec) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (atWrap) begin
                        if (bitIdx == LAST_BIT) state <= HAS_PAR ? ST_PARITY : ST_STOP;
                        else                    bitIdx <= bitIdx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (atDec)  parErr <= maj ^ (^shreg) ^ ODD_FLIP;
                    if (atWrap) state  <= ST_STOP;
                end
                ST_STOP: if (atDec) begin
                    // Completion is judged here so a same-cycle handshake frees the slot.
                    if (isBreak) begin
                        rx_break <= 1'b1;
                        state    <= ST_WAIT_HIGH;
                    end else begin
                        if (rx_valid && !rx_ready) begin
                            rx_overrun <= 1'b1;
                        end else begin
                            rx_data       <= shreg;
                            rx_parity_err <= parErr;
                            rx_frame_err  <= !maj;
                            rx_valid      <= 1'b1;
                        end
                        state <= maj ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: if (tick && lineS) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: scoreboard bench for uart_rx_gen2 (8N1 and 7E1 instances, 16 clk/bit).
module tb_uart_rx_gen2;
    localparam int LAT = 157;  // first-edge-of-start to rx_valid, 10-bit frame at 16 clk/bit

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rxd8, rdy8, v8, pe8, fe8, ov8, brk8, busy8;
    logic [7:0] d8;
    logic       rxd7, rdy7, v7, pe7, fe7, ov7, brk7, busy7;
    logic [6:0] d7;

    uart_rx_gen2 #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .SYNC_STAGES(2)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd8), .rx_data(d8), .rx_valid(v8),
        .rx_ready(rdy8), .rx_parity_err(pe8), .rx_frame_err(fe8),
        .rx_overrun(ov8), .rx_break(brk8), .rx_busy(busy8)
    );

    uart_rx_gen2 #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
        .DATA_BITS(7), .PARITY(2), .SYNC_STAGES(2)
    ) dut7 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd7), .rx_data(d7), .rx_valid(v7),
        .rx_ready(rdy7), .rx_parity_err(pe7), .rx_frame_err(fe7),
        .rx_overrun(ov7), .rx_break(brk7), .rx_busy(busy7)
    );

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
        bit         chkLat;
    } exp_t;

    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    int total = 0, bad = 0, cyc = 0;
    int ovCount = 0, brkCount = 0, side7Count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic [8:0] d, input logic pe, input logic fe, input bit lat);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.t0 = 0; e.chkLat = lat;
        return e;
    endfunction

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stopBit);
        return {6'b0, stopBit, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7(input logic [6:0] d, input logic parBit);
        return {6'b0, 1'b1, parBit, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8) ovCount++;
            if (brk8) brkCount++;
            if (ov7 || brk7) side7Count++;
            if (v8 && rdy8) begin
                if (q8.size() == 0) checkEq("q8_word_expected", q8.size(), 1);
                else begin
                    e8 = q8.pop_front();
                    checkEq("d8_data", d8, e8.data);
                    checkEq("d8_perr", pe8, e8.perr);
                    checkEq("d8_ferr", fe8, e8.ferr);
                    if (e8.chkLat) checkEq("d8_latency", cyc - e8.t0, LAT);
                end
            end
            if (v7 && rdy7) begin
                if (q7.size() == 0) checkEq("q7_word_expected", q7.size(), 1);
                else begin
                    e7 = q7.pop_front();
                    checkEq("d7_data", d7, e7.data);
                    checkEq("d7_perr", pe7, e7.perr);
                    checkEq("d7_ferr", fe7, e7.ferr);
                    if (e7.chkLat) checkEq("d7_latency", cyc - e7.t0, LAT);
                end
            end
        end
    end

    // Each bit lasts 16 clocks; `spike` flips the line for one clock at phase 8 of that bit.
    task automatic sendFrame(input int sel, input logic [15:0] fr, input int n, input int spike,
                             input bit doPush, input exp_t e);
        exp_t ee;
        ee = e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            if (sel == 0) rxd8 = fr[i]; else rxd7 = fr[i];
            if (i == 0) begin
                ee.t0 = cyc;
                if (doPush) begin
                    if (sel == 0) q8.push_back(ee); else q7.push_back(ee);
                end
            end
            if (i == spike) begin
                repeat (9) @(posedge clk);
                #2;
                if (sel == 0) rxd8 = ~fr[i]; else rxd7 = ~fr[i];
                @(posedge clk); #2;
                if (sel == 0) rxd8 = fr[i]; else rxd7 = fr[i];
                repeat (5) @(posedge clk);
            end else begin
                repeat (15) @(posedge clk);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] pd;
        logic       pb;
        rst_n = 1'b0; rxd8 = 1'b1; rxd7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("rst_valid", v8, 0);
        checkEq("rst_busy", busy8, 0);
        checkEq("rst_data", d8, 0);
        checkEq("rst_errs", {pe8, fe8, ov8, brk8}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        sendFrame(0, frame8(8'hA5, 1'b1), 10, -1, 1'b1, mkExp(9'hA5, 1'b0, 1'b0, 1'b1));
        sendFrame(0, frame8(8'h81, 1'b1), 10, 1, 1'b1, mkExp(9'h81, 1'b0, 1'b0, 1'b1));
        repeat (20) @(posedge clk);

        @(posedge clk); #2 rxd8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rxd8 = 1'b1;
        @(negedge clk);
        checkEq("glitch_busy_hi", busy8, 1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkEq("glitch_busy_lo", busy8, 0);
        checkEq("glitch_valid", v8, 0);

        pd = 7'h35;
        for (int k = 0; k < 2; k++) begin
            pb = (k == 0) ? 1'b1 : 1'b0;
            sendFrame(1, frame7(pd, pb), 10, -1, 1'b1, mkExp({2'b0, pd}, pb ^ (^pd), 1'b0, 1'b1));
        end
        repeat (20) @(posedge clk);

        rdy8 = 1'b0;
        sendFrame(0, frame8(8'h11, 1'b1), 10, -1, 1'b1, mkExp(9'h11, 1'b0, 1'b0, 1'b0));
        sendFrame(0, frame8(8'h22, 1'b1), 10, -1, 1'b0, mkExp(9'h22, 1'b0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkEq("ovr_hold_data", d8, 8'h11);
        checkEq("ovr_hold_valid", v8, 1);
        checkEq("ovr_count", ovCount, 1);
        @(posedge clk); #2 rdy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkEq("ovr_valid_drop", v8, 0);

        sendFrame(0, frame8(8'h7E, 1'b0), 10, -1, 1'b1, mkExp(9'h7E, 1'b0, 1'b1, 1'b1));
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkEq("ferr_wait_high", busy8, 1);
        @(posedge clk); #2 rxd8 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkEq("ferr_back_idle", busy8, 0);

        sendFrame(0, frame8(8'h3C, 1'b1), 5, -1, 1'b0, mkExp(9'h3C, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkEq("mid_frame_busy", busy8, 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checkEq("arst_data", d8, 0);
        checkEq("arst_flags", {v8, pe8, fe8, ov8, brk8, busy8}, 0);
        rxd8 = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        sendFrame(0, frame8(8'h3C, 1'b1), 10, -1, 1'b1, mkExp(9'h3C, 1'b0, 1'b0, 1'b1));
        repeat (10) @(posedge clk);

`ifdef UART_RX_BREAK_DETECT_EN
        sendFrame(0, 16'h0000, 12, -1, 1'b0, mkExp(9'h0, 1'b0, 1'b1, 1'b1));
`else
        sendFrame(0, 16'h0000, 12, -1, 1'b1, mkExp(9'h0, 1'b0, 1'b1, 1'b1));
`endif
        @(negedge clk);
        checkEq("break_wait_high", busy8, 1);
        @(posedge clk); #2 rxd8 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkEq("break_back_idle", busy8, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        checkEq("break_pulses", brkCount, 1);
`else
        checkEq("break_pulses", brkCount, 0);
`endif

        repeat (20) @(posedge clk);
        @(negedge clk);
        checkEq("q8_drained", q8.size(), 0);
        checkEq("q7_drained", q7.size(), 0);
        checkEq("ovr_total", ovCount, 1);
        checkEq("dut7_side_pulses", side7Count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
